muldiv_unit: RTL

Iterative integer multiply/divide unit implementing RV64M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus W variants) for the execute stage, next to the ALU. Parametrised in data width and sideband tag width. One quotient/product bit per cycle. Valid/ready handshakes on both sides. A kill input discards in-flight work on a pipeline flush.

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit, one product/quotient bit per cycle, valid/ready on both sides.
module muldiv_unit #(
    parameter int Xlen = 64,
    parameter int TagW = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      op_i,
    input  logic [Xlen-1:0] a_i,
    input  logic [Xlen-1:0] b_i,
    input  logic [TagW-1:0] tag_i,
    input  logic            kill_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [Xlen-1:0] result_o,
    output logic [TagW-1:0] tag_o,
    output logic            busy_o
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    localparam int CntW = $clog2(Xlen + 1);
    localparam int Dw = 2 * Xlen;

    function automatic logic [Xlen-1:0] wext(input logic [Xlen-1:0] v, input logic s);
        logic [Xlen-1:0] r;
        r = v;
        for (int i = 32; i < Xlen; i++) r[i] = s & v[31];
        return r;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [Dw-1:0]   acc_q, acc_d;
    logic [Xlen-1:0] b_q, b_d, res_q, res_d;
    logic [TagW-1:0] tag_q, tag_d;
    logic [4:0]      cfg_q, cfg_d;

    logic            word, rsvd, is_div, sa_en, sb_en, sa, sb, div0, ovf, fast, ge, last;
    logic [Xlen-1:0] aw, bw, ma, mb, min_mag, fast_res, dv, dn, raw;
    logic [Xlen:0]   msum, rtry, diff;
    logic [Dw-1:0]   step, pv, pn;

    assign word     = (Xlen == 64) && op_i[3];
    assign rsvd     = op_i[3] && !op_i[2] && (op_i[1:0] != 2'd0);
    assign is_div   = op_i[2];
    assign sa_en    = is_div ? !op_i[0] : (op_i[1:0] != 2'd3);
    assign sb_en    = is_div ? !op_i[0] : !op_i[1];
    assign aw       = word ? wext(a_i, sa_en) : a_i;
    assign bw       = word ? wext(b_i, sb_en) : b_i;
    assign sa       = sa_en & aw[Xlen-1];
    assign sb       = sb_en & bw[Xlen-1];
    assign ma       = sa ? -aw : aw;
    assign mb       = sb ? -bw : bw;
    assign min_mag  = word ? Xlen'(1) << 31 : Xlen'(1) << (Xlen - 1);
    assign div0     = is_div && (bw == '0);
    assign ovf      = is_div && sa && sb && (ma == min_mag) && (bw == '1);
    assign fast     = rsvd || div0 || ovf;
    assign fast_res = rsvd ? '0 : div0 ? (op_i[1] ? aw : '1) : (op_i[1] ? '0 : aw);

    // cfg_q = {word, div, rem, mul-high, negate-result}
    assign msum = {1'b0, acc_q[Dw-1:Xlen]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign rtry = acc_q[Dw-1:Xlen-1];
    assign diff = rtry - {1'b0, b_q};
    assign ge   = !diff[Xlen];
    assign step = cfg_q[3] ? {ge ? diff[Xlen-1:0] : rtry[Xlen-1:0], acc_q[Xlen-2:0], ge}
                           : {msum, acc_q[Xlen-1:1]};
    assign pv   = cfg_q[4] ? acc_q >> 32 : acc_q;
    assign pn   = cfg_q[0] ? -pv : pv;
    assign dv   = cfg_q[2] ? acc_q[Dw-1:Xlen] : acc_q[Xlen-1:0];
    assign dn   = cfg_q[0] ? -dv : dv;
    assign raw  = cfg_q[3] ? dn : cfg_q[1] ? pn[Dw-1:Xlen] : pn[Xlen-1:0];
    // Sign correction gets its own cycle after the last step, keeping the negate off the adder path.
    assign last = cnt_q == (cfg_q[4] ? CntW'(32) : CntW'(Xlen));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        cfg_d   = cfg_q;
        res_d   = res_q;
        tag_d   = tag_q;
        if (kill_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE && in_valid_i) begin
            state_d = fast ? DONE : CALC;
            cnt_d   = '0;
            acc_d   = {{Xlen{1'b0}}, is_div && word ? ma << 32 : ma};
            b_d     = mb;
            cfg_d   = {word, is_div, op_i[1], op_i[1:0] != 2'd0, is_div && op_i[1] ? sa : sa ^ sb};
            tag_d   = tag_i;
            res_d   = fast ? (word ? wext(fast_res, 1'b1) : fast_res) : res_q;
        end else if (state_q == CALC) begin
            state_d = last ? DONE : CALC;
            res_d   = last ? (cfg_q[4] ? wext(raw, 1'b1) : raw) : res_q;
            acc_d   = last ? acc_q : step;
            cnt_d   = last ? cnt_q : cnt_q + 1'b1;
        end else if (state_q == DONE && out_ready_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            cfg_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            cfg_q   <= cfg_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready_o  = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign out_valid_o = (state_q == DONE) && !kill_i;
    assign result_o    = res_q;
    assign tag_o       = tag_q;
endmodule
